// File: rtl/matrix_mul_param.sv
// rtl/matrix_mul_param.sv - parameterized output-stationary systolic matrix multiplier
// Purpose: computes C = A * B (A is ROW x NUM, B is NUM x COL) on a ROW x COL
//          output-stationary systolic array; one job in, one result out.
// Ports:   clk, rst_n      clock, asynchronous active-low reset
//          in_vld/in_rdy   job handshake; din_A (row-major A), din_B (B transposed)
//          out_vld/out_rdy result handshake; dout_C (row-major C, registered)
//          busy            high whenever the FSM is not idle
//          acc_clr         only with MATRIX_MUL_ACC_EN: 1 clears, 0 accumulates
// Option:  define MATRIX_MUL_ACC_EN to enable accumulate mode.
module matrix_mul_param #(
  parameter int DATA_W = 8,
  parameter int ROW    = 3,
  parameter int COL    = 3,
  parameter int NUM    = 3,
  parameter int SIGNED = 0,
  localparam int ACC_W = 2 * DATA_W + $clog2(NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef MATRIX_MUL_ACC_EN
  input  logic                      acc_clr,
`endif
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [DATA_W*ROW*NUM-1:0] din_A,
  input  logic [DATA_W*COL*NUM-1:0] din_B,
  input  logic                      out_rdy,
  output logic                      out_vld,
  output logic [ACC_W*ROW*COL-1:0]  dout_C,
  output logic                      busy
);

  localparam int AW       = DATA_W * ROW * NUM;
  localparam int BW       = DATA_W * COL * NUM;
  localparam int CW       = ACC_W * ROW * COL;
  localparam int FEED_LEN = NUM + ROW + COL - 2;
  localparam int CNT_W    = $clog2(FEED_LEN + 3);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
  // Three drain cycles: the last product is accumulated on the first drain
  // edge, and the total accept-to-out_vld latency comes to NUM+ROW+COL+1.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              clr_acc;
  logic [AW-1:0]     a_cap_q;
  logic [BW-1:0]     b_cap_q;
  logic [DATA_W-1:0] a_q   [ROW][COL];
  logic [DATA_W-1:0] b_q   [ROW][COL];
  logic [ACC_W-1:0]  acc_q [ROW][COL];
  logic [DATA_W-1:0] a_in  [ROW];
  logic [DATA_W-1:0] b_in  [COL];
  logic [CW-1:0]     dout_q;

`ifdef MATRIX_MUL_ACC_EN
  assign clr_acc = acc_clr;
`else
  assign clr_acc = 1'b1;
`endif

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    else             return {{(ACC_W-DATA_W){1'b0}}, v};
  endfunction

  // FSM: next state, counter and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_rdy = 1'b1;
        busy   = 1'b0;
        if (in_vld) begin
          accept  = 1'b1;
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = S_DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Skewed edge feed: during feed step t, row r takes A[r][t-r] and column c
  // takes B[t-c][c]; outside that window a zero is injected.
  always_comb begin
    for (int r = 0; r < ROW; r++) begin
      a_in[r] = '0;
      if (state_q == S_FEED)
        for (int k = 0; k < NUM; k++)
          if (cnt_q == CNT_W'(r + k)) a_in[r] = a_cap_q[DATA_W*(r*NUM+k) +: DATA_W];
    end
    for (int c = 0; c < COL; c++) begin
      b_in[c] = '0;
      if (state_q == S_FEED)
        for (int k = 0; k < NUM; k++)
          if (cnt_q == CNT_W'(c + k)) b_in[c] = b_cap_q[DATA_W*(c*NUM+k) +: DATA_W];
    end
  end

  // Datapath: operand capture, systolic shift, multiply-accumulate, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cap_q <= '0;
      b_cap_q <= '0;
      dout_q  <= '0;
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          acc_q[r][c] <= '0;
        end
    end else begin
      if (accept) begin
        a_cap_q <= din_A;
        b_cap_q <= din_B;
        // Pipeline registers are flushed so no stale operand leaks into the job.
        for (int r = 0; r < ROW; r++)
          for (int c = 0; c < COL; c++) begin
            a_q[r][c] <= '0;
            b_q[r][c] <= '0;
            if (clr_acc) acc_q[r][c] <= '0;
          end
      end else if (state_q == S_FEED || state_q == S_DRAIN) begin
        for (int r = 0; r < ROW; r++) begin
          a_q[r][0] <= a_in[r];
          for (int c = 1; c < COL; c++) a_q[r][c] <= a_q[r][c-1];
        end
        for (int c = 0; c < COL; c++) begin
          b_q[0][c] <= b_in[c];
          for (int r = 1; r < ROW; r++) b_q[r][c] <= b_q[r-1][c];
        end
        for (int r = 0; r < ROW; r++)
          for (int c = 0; c < COL; c++)
            acc_q[r][c] <= acc_q[r][c] + ext(a_q[r][c]) * ext(b_q[r][c]);
      end
      if (state_q == S_DRAIN && state_d == S_DONE)
        for (int r = 0; r < ROW; r++)
          for (int c = 0; c < COL; c++)
            dout_q[ACC_W*(r*COL+c) +: ACC_W] <= acc_q[r][c];
    end
  end

  assign dout_C = dout_q;

endmodule

// File: tb/tb_matrix_mul_param.sv
// tb/tb_matrix_mul_param.sv - scoreboard bench for matrix_mul_param (unsigned and signed instances)
module tb_matrix_mul_param;
  localparam int DATA_W = 8;
  localparam int ROW    = 3;
  localparam int COL    = 3;
  localparam int NUM    = 3;
  localparam int ACC_W  = 2 * DATA_W + $clog2(NUM);
  localparam int L      = NUM + ROW + COL + 1;
  localparam int AW     = DATA_W * ROW * NUM;
  localparam int BW     = DATA_W * COL * NUM;
  localparam int CW     = ACC_W * ROW * COL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic          out_rdy = 1'b1;
  logic [AW-1:0] din_A = '0;
  logic [BW-1:0] din_B = '0;
  logic          in_rdy_u, out_vld_u, busy_u;
  logic          in_rdy_s, out_vld_s, busy_s;
  logic [CW-1:0] dout_u, dout_s;
`ifdef MATRIX_MUL_ACC_EN
  logic          acc_clr = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [CW-1:0] exp_u_q[$];
  logic [CW-1:0] exp_s_q[$];
  logic [CW-1:0] last_u = '0;
  logic [CW-1:0] last_s = '0;

  matrix_mul_param #(.DATA_W(DATA_W), .ROW(ROW), .COL(COL), .NUM(NUM), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n),
`ifdef MATRIX_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .in_vld(in_vld), .in_rdy(in_rdy_u), .din_A(din_A), .din_B(din_B),
    .out_rdy(out_rdy), .out_vld(out_vld_u), .dout_C(dout_u), .busy(busy_u)
  );

  matrix_mul_param #(.DATA_W(DATA_W), .ROW(ROW), .COL(COL), .NUM(NUM), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n),
`ifdef MATRIX_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .in_vld(in_vld), .in_rdy(in_rdy_s), .din_A(din_A), .din_B(din_B),
    .out_rdy(out_rdy), .out_vld(out_vld_s), .dout_C(dout_s), .busy(busy_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                          input bit sgn, input logic [CW-1:0] base);
    logic [CW-1:0] res;
    res = '0;
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) begin
        longint s;
        s = 0;
        for (int k = 0; k < NUM; k++) begin
          logic [7:0] ea, eb;
          longint x, y;
          ea = a[DATA_W*(r*NUM+k) +: DATA_W];
          eb = b[DATA_W*(c*NUM+k) +: DATA_W];
          x = sgn ? longint'($signed(ea)) : longint'(ea);
          y = sgn ? longint'($signed(eb)) : longint'(eb);
          s = s + x * y;
        end
        res[ACC_W*(r*COL+c) +: ACC_W] = base[ACC_W*(r*COL+c) +: ACC_W] + s[ACC_W-1:0];
      end
    return res;
  endfunction

  function automatic logic [AW-1:0] fill(input logic [7:0] v);
    logic [AW-1:0] m;
    for (int i = 0; i < ROW*NUM; i++) m[8*i +: 8] = v;
    return m;
  endfunction

  function automatic logic [AW-1:0] rand_mat();
    logic [AW-1:0] m;
    for (int i = 0; i < ROW*NUM; i++) m[8*i +: 8] = 8'($urandom);
    return m;
  endfunction

  function automatic logic [AW-1:0] ident();
    logic [AW-1:0] m;
    m = '0;
    for (int i = 0; i < ROW; i++) m[8*(i*NUM+i) +: 8] = 8'd1;
    return m;
  endfunction

  // Drives one job from a negedge, scoreboards it and checks the result handshake.
  task automatic run_job(input logic [AW-1:0] a, input logic [BW-1:0] b, input int stall,
                         input string name);
    int t, acc_cyc;
    logic [CW-1:0] base_u, base_s, eu, es, hold;
    t = 0;
    while (!in_rdy_u && t < 100) begin @(negedge clk); t++; end
    base_u = '0;
    base_s = '0;
`ifdef MATRIX_MUL_ACC_EN
    if (!acc_clr) begin base_u = last_u; base_s = last_s; end
`endif
    eu = model(a, b, 1'b0, base_u);
    es = model(a, b, 1'b1, base_s);
    exp_u_q.push_back(eu);
    exp_s_q.push_back(es);
    last_u = eu;
    last_s = es;
    din_A = a;
    din_B = b;
    in_vld = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_vld = 1'b0;
    din_A = rand_mat();
    din_B = rand_mat();
    out_rdy = (stall == 0);
    checks++;
    if (busy_u !== 1'b1 || in_rdy_u !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy=%b in_rdy=%b expected busy=1 in_rdy=0", name, busy_u, in_rdy_u);
    end
    t = 0;
    while (!out_vld_u && t < 4*L) begin @(negedge clk); t++; end
    eu = exp_u_q.pop_front();
    es = exp_s_q.pop_front();
    checks++;
    if (!out_vld_u) begin
      errors++;
      $display("FAIL %s timeout: out_vld=%b expected 1 within %0d cycles", name, out_vld_u, 4*L);
    end else begin
      checks++;
      if (cyc - acc_cyc !== L || out_vld_s !== 1'b1) begin
        errors++;
        $display("FAIL %s latency: got %0d (signed vld %b) expected %0d", name, cyc - acc_cyc, out_vld_s, L);
      end
      checks++;
      if (dout_u !== eu) begin
        errors++;
        $display("FAIL %s unsigned C: got %h expected %h", name, dout_u, eu);
      end
      checks++;
      if (dout_s !== es) begin
        errors++;
        $display("FAIL %s signed C: got %h expected %h", name, dout_s, es);
      end
      hold = dout_u;
      for (int i = 0; i < stall; i++) begin
        in_vld = i[0];
        din_A = rand_mat();
        @(negedge clk);
        checks++;
        if (out_vld_u !== 1'b1 || dout_u !== hold || in_rdy_u !== 1'b0 || busy_u !== 1'b1) begin
          errors++;
          $display("FAIL %s stall%0d: vld=%b in_rdy=%b busy=%b C=%h expected vld=1 in_rdy=0 busy=1 C=%h",
                   name, i, out_vld_u, in_rdy_u, busy_u, dout_u, hold);
        end
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (out_vld_u !== 1'b0 || in_rdy_u !== 1'b1 || busy_u !== 1'b0) begin
        errors++;
        $display("FAIL %s release: vld=%b in_rdy=%b busy=%b expected 0 1 0", name, out_vld_u, in_rdy_u, busy_u);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_rdy_u !== 1'b1 || in_rdy_s !== 1'b1 || out_vld_u !== 1'b0 || out_vld_s !== 1'b0 ||
        busy_u !== 1'b0 || busy_s !== 1'b0 || dout_u !== '0 || dout_s !== '0) begin
      errors++;
      $display("FAIL reset_state: in_rdy=%b vld=%b busy=%b C=%h expected 1 0 0 0", in_rdy_u, out_vld_u, busy_u, dout_u);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    logic [BW-1:0] b;
    logic [CW-1:0] direct;
    for (int k = 0; k < NUM; k++)
      for (int c = 0; c < COL; c++) b[8*(c*NUM+k) +: 8] = 8'(k*COL + c + 1);
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) direct[ACC_W*(r*COL+c) +: ACC_W] = ACC_W'(r*COL + c + 1);
    run_job(ident(), b, 0, "identity");
    checks++;
    if (dout_u !== direct) begin
      errors++;
      $display("FAIL identity_direct: got %h expected %h", dout_u, direct);
    end
  endtask

  task automatic test_extremes();
    run_job(fill(8'hFF), fill(8'hFF), 0, "all_ff");
    for (int i = 0; i < ROW*COL; i++) begin
      checks++;
      if (dout_u[ACC_W*i +: ACC_W] !== 18'h2FA03 || dout_s[ACC_W*i +: ACC_W] !== 18'd3) begin
        errors++;
        $display("FAIL all_ff_elem%0d: got u=%h s=%h expected 2fa03 and 3", i, dout_u[ACC_W*i +: ACC_W], dout_s[ACC_W*i +: ACC_W]);
      end
    end
    run_job(fill(8'h80), fill(8'h80), 0, "all_80");
    checks++;
    if (dout_s[ACC_W*4 +: ACC_W] !== 18'd49152) begin
      errors++;
      $display("FAIL all_80: got %0d expected 49152", dout_s[ACC_W*4 +: ACC_W]);
    end
    run_job(fill(8'h80), fill(8'h7F), 0, "mix_80_7f");
    checks++;
    if ($signed(dout_s[ACC_W*8 +: ACC_W]) !== -18'sd48768) begin
      errors++;
      $display("FAIL mix_80_7f: got %0d expected -48768", $signed(dout_s[ACC_W*8 +: ACC_W]));
    end
  endtask

  task automatic test_backpressure();
    run_job(rand_mat(), rand_mat(), 20, "backpressure");
  endtask

  task automatic test_reset_midjob();
    bit seen;
    din_A = rand_mat();
    din_B = rand_mat();
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (out_vld_u) seen = 1'b1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_u !== 1'b0 || in_rdy_u !== 1'b1 || out_vld_u !== 1'b0 || dout_u !== '0 || dout_s !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b in_rdy=%b vld=%b C=%h expected 0 1 0 0", busy_u, in_rdy_u, out_vld_u, dout_u);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_u = '0;
    last_s = '0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_vld: out_vld seen=1 expected 0");
    end
    run_job(rand_mat(), rand_mat(), 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 6; j++)
      run_job(rand_mat(), rand_mat(), int'($urandom_range(0, 3)), $sformatf("b2b%0d", j));
  endtask

`ifdef MATRIX_MUL_ACC_EN
  task automatic test_accumulate();
    logic [CW-1:0] two_i;
    two_i = '0;
    for (int i = 0; i < ROW; i++) two_i[ACC_W*(i*COL+i) +: ACC_W] = ACC_W'(2);
    acc_clr = 1'b1;
    run_job(ident(), ident(), 0, "acc_job1");
    acc_clr = 1'b0;
    run_job(ident(), ident(), 0, "acc_job2");
    acc_clr = 1'b1;
    checks++;
    if (dout_u !== two_i) begin
      errors++;
      $display("FAIL accumulate: got %h expected %h", dout_u, two_i);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_backpressure();
    test_reset_midjob();
    test_back_to_back();
`ifdef MATRIX_MUL_ACC_EN
    test_accumulate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_mul_param.md
MATRIX_MUL_PARAM -- requirements
Module: matrix_mul_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand element width in bits.
REQ-002 SHALL have parameter ROW, default 3: rows of A and C.
REQ-003 SHALL have parameter COL, default 3: columns of B and C.
REQ-004 SHALL have parameter NUM, default 3: columns of A and rows of B (inner dimension).
REQ-005 SHALL have parameter SIGNED, default 0: 1 selects two's-complement operands, 0 selects unsigned operands.
REQ-006 SHALL have localparam ACC_W = 2*DATA_W + clog2(NUM): result element width.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 in_vld  input  1  din_A/din_B valid.
REQ-010 in_rdy  output  1  block can accept a job.
REQ-011 din_A  input  DATA_W*ROW*NUM  A[r][k] at bit offset DATA_W*(r*NUM+k).
REQ-012 din_B  input  DATA_W*COL*NUM  B transposed: B[k][c] at bit offset DATA_W*(c*NUM+k).
REQ-013 out_rdy  input  1  downstream accepts the result.
REQ-014 out_vld  output  1  dout_C holds a complete result.
REQ-015 dout_C  output  ACC_W*ROW*COL  C[r][c] at bit offset ACC_W*(r*COL+c), registered.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL compute C[r][c] = sum over k of A[r][k]*B[k][c], with products and sums sign- or zero-extended to ACC_W according to SIGNED; the result SHALL be exact (no overflow) for a single job.
REQ-018 SHALL accept a job on the rising edge where in_vld and in_rdy are both 1; din_A/din_B SHALL be captured on that edge and SHALL NOT be sampled again during the job.
REQ-019 in_rdy SHALL be 1 only in IDLE; in_vld in any other state SHALL be ignored.
REQ-020 FSM states: IDLE -> FEED on accept; FEED -> DRAIN after NUM+ROW+COL-2 feed cycles; DRAIN -> DONE after the array settles; DONE -> IDLE on the edge where out_vld and out_rdy are both 1.
REQ-021 Computation SHALL use a ROW x COL output-stationary systolic array. Row r of A SHALL enter skewed by r cycles, column c of B SHALL enter skewed by c cycles, and zeros SHALL be injected outside the valid window.
REQ-022 out_vld SHALL rise exactly L = NUM+ROW+COL+1 cycles after the accept edge.
REQ-023 out_vld and dout_C SHALL hold stable while out_rdy is 0. Backpressure duration SHALL be unbounded.
REQ-024 If out_rdy is 1 when out_vld rises, the handshake SHALL complete on that edge and in_rdy SHALL be 1 in the next cycle.
REQ-025 The accumulator array SHALL be cleared at each accept, except as stated in REQ-030.
REQ-026 dout_C SHALL update only on the transition into DONE.

Reset
REQ-027 On rst_n low, the FSM SHALL go to IDLE, and in_rdy SHALL be 1, out_vld 0, busy 0, dout_C 0, and all accumulators and skew registers 0, asynchronously.
REQ-028 Reset mid-job SHALL abort the job, produce no out_vld, and allow a new job to be accepted on the first edge after rst_n deasserts.

Configuration
REQ-029 Macro MATRIX_MUL_ACC_EN SHALL control accumulate mode.
REQ-030 With MATRIX_MUL_ACC_EN defined, the block SHALL add input acc_clr (1 bit, sampled with the accept), and accumulators SHALL be cleared at accept only when acc_clr=1, otherwise retained, giving C_new = C_prev + A*B. The sum SHALL wrap modulo 2^ACC_W.
REQ-031 Without MATRIX_MUL_ACC_EN, the acc_clr port SHALL be absent and every job SHALL clear the accumulators.

Verification (DATA_W=8, ROW=COL=NUM=3, L=10)
REQ-032 A=identity, B=[1..9], SIGNED=0, out_rdy=1 -> C=B, out_vld high exactly 10 cycles after accept, for 1 cycle.
REQ-033 All A,B=8'hFF, SIGNED=0 -> every C=195075 (18'h2FA03); SIGNED=1 -> every C=3.
REQ-034 All A,B=8'h80, SIGNED=1 -> every C=49152; A=8'h80, B=8'h7F -> every C=-48768.
REQ-035 out_rdy=0 for 20 cycles after out_vld -> dout_C and out_vld stable, in_rdy 0, in_vld pulses ignored; out_rdy=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low at cycle 5 of a job -> out_vld never rises for that job; a new job accepted immediately after gives the correct result at L.
REQ-037 MATRIX_MUL_ACC_EN: job1 acc_clr=1 with A=B=identity, then job2 acc_clr=0 with A=B=identity -> C diagonal 2, off-diagonal 0.
